// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - user-side start/busy/done handshake and operand/result bus
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller driving one external full adder LSB-first
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus,
    output logic                fa_a,
    output logic                fa_b,
    output logic                fa_cin,
    input  logic                fa_sum,
    input  logic                fa_cout
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    // The full adder is combinational, so its outputs come back within the same cycle.
    assign fa_a   = (state == RUN) & a_sh[0];
    assign fa_b   = (state == RUN) & b_sh[0];
    assign fa_cin = (state == RUN) & carry;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Last bit: publish straight from the adder so the result lands with done.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum_r  <= {fa_sum, sum_sh[WIDTH-1:1]};
                        cout_r <= fa_cout;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl with a real full adder
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic ha1_s, ha1_c, ha2_c;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    // Full adder built from two half adders and an OR
    assign ha1_s   = fa_a ^ fa_b;
    assign ha1_c   = fa_a & fa_b;
    assign fa_sum  = ha1_s ^ fa_cin;
    assign ha2_c   = ha1_s & fa_cin;
    assign fa_cout = ha1_c | ha2_c;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "since" counts edges after the accepting edge, -1 when idle.
    int m_since = -1;
    int m_a = 0, m_b = 0, m_c = 0;
    int m_sum = 0, m_cout = 0;
    int done_seen = 0;

    always @(posedge clk) begin
        int res, mask, e_fa_a, e_fa_b, e_fa_cin;
        if (rst) begin
            m_since = -1;
            m_sum   = 0;
            m_cout  = 0;
        end else if (m_since < 0) begin
            if (bus.start) begin
                m_a = int'(bus.a);
                m_b = int'(bus.b);
                m_c = int'(bus.cin);
                m_since = 0;
            end
        end else begin
            m_since++;
            if (m_since == W) begin
                res    = m_a + m_b + m_c;
                m_sum  = res & 255;
                m_cout = (res >> 8) & 1;
            end else if (m_since == W + 1) begin
                m_since = -1;
            end
        end
        #2;
        e_fa_a = 0; e_fa_b = 0; e_fa_cin = 0;
        if (m_since >= 0 && m_since < W) begin
            mask     = (1 << m_since) - 1;
            e_fa_a   = (m_a >> m_since) & 1;
            e_fa_b   = (m_b >> m_since) & 1;
            e_fa_cin = (((m_a & mask) + (m_b & mask) + m_c) >> m_since) & 1;
        end
        chk("busy",   int'(bus.busy), (m_since >= 0 && m_since < W) ? 1 : 0);
        chk("done",   int'(bus.done), (m_since == W) ? 1 : 0);
        chk("sum",    int'(bus.sum),  m_sum);
        chk("cout",   int'(bus.cout), m_cout);
        chk("fa_a",   int'(fa_a),     e_fa_a);
        chk("fa_b",   int'(fa_b),     e_fa_b);
        chk("fa_cin", int'(fa_cin),   e_fa_cin);
        if (bus.done) done_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present start for one edge, then wait (bounded) for done; cycles counts the start edge too.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int s, output int co, output int cycles);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cycles = 1;
        while (!bus.done && cycles < 20) begin
            step();
            cycles++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
        s  = int'(bus.sum);
        co = int'(bus.cout);
        step();
    endtask

    initial begin
        int s, co, cyc, last_done, nd;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // 1. reset
        rst = 1'b1;
        step(); step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sum",  int'(bus.sum),  0);
        chk("rst_cout", int'(bus.cout), 0);
        chk("rst_fa",   int'({fa_a, fa_b, fa_cin}), 0);
        rst = 1'b0;
        step();

        // 2. basic add and latency
        run_op(8'h35, 8'h4A, 1'b0, s, co, cyc);
        chk("t2_sum", s, 8'h7F);
        chk("t2_cout", co, 0);
        chk("t2_latency", cyc, 9);
        chk("t2_hold_sum", int'(bus.sum), 8'h7F);

        // 3. full carry ripple
        run_op(8'hFF, 8'h01, 1'b1, s, co, cyc);
        chk("t3_sum", s, 8'h01);
        chk("t3_cout", co, 1);
        run_op(8'hFF, 8'hFF, 1'b1, s, co, cyc);
        chk("t3b_sum", s, 8'hFF);
        chk("t3b_cout", co, 1);

        // 4. start held: accepts every 10 cycles, extra starts ignored
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
        nd = 0; last_done = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) begin
                chk("t4_sum", int'(bus.sum), 8'h30);
                if (last_done >= 0) chk("t4_period", i - last_done, 10);
                last_done = i;
                nd++;
            end
        end
        bus.start = 1'b0;
        chk("t4_count", nd, 3);
        step(); step();

        // 5. operands change mid-run, then reset aborts with no done
        nd = done_seen;
        bus.a = 8'h55; bus.b = 8'h0F; bus.cin = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        bus.a = 8'hAA; bus.b = 8'hF0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_sum",  int'(bus.sum),  0);
        chk("t5_cout", int'(bus.cout), 0);
        for (int i = 0; i < 12; i++) step();
        chk("t5_no_done", done_seen - nd, 0);
        run_op(8'h12, 8'h34, 1'b1, s, co, cyc);
        chk("t5_new_sum", s, 8'h47);
        chk("t5_new_cout", co, 0);

        // 6. random operations, model checks every cycle
        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), s, co, cyc);
            chk("t6_latency", cyc, 9);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
